// File: rtl/hv_sram_pkg.sv
// Shared constants and bank mapping for the HV SRAM read scheduler.
// Modality m owns banks m*BANKS_PER_MOD .. m*BANKS_PER_MOD+BANKS_PER_MOD-1.
package hv_sram_pkg;

  localparam int NUM_MOD       = 3;
  localparam int BANKS_PER_MOD = 3;
  localparam int NUM_BANKS     = NUM_MOD * BANKS_PER_MOD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_HOLD = 2'd2
  } state_e;

  function automatic int bank_to_mod(input int bank);
    return bank / BANKS_PER_MOD;
  endfunction

  // Expands a per-modality request vector to a per-bank mask.
  function automatic logic [NUM_BANKS-1:0] req_to_mask(input logic [NUM_MOD-1:0] req);
    logic [NUM_BANKS-1:0] mask;
    mask = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      mask[b] = req[bank_to_mod(b)];
    end
    return mask;
  endfunction

endpackage

// File: rtl/hv_sram_starve_ctr.sv
// Saturating loader wait counter; o_starve flags that the loader has waited
// STARVE_LIMIT cycles and must pre-empt the next read issue.
module hv_sram_starve_ctr #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  input  logic i_clr,
  output logic o_starve
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_wait && !o_starve) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starve = (r_cnt == CW'(STARVE_LIMIT));

endmodule

// File: rtl/hv_sram_read_scheduler.sv
// Schedules encoder reads of the nine projection/item-memory banks and
// interleaves host loader writes on the shared bank ports.
module hv_sram_read_scheduler
  import hv_sram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 2000,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RBI,
  input  logic [NUM_MOD-1:0]    EncReq_SI,
  input  logic [ADDR_WIDTH-1:0] EncAddr_DI,
  output logic [NUM_BANKS-1:0]  EncValid_SO,
  input  logic                  LdValid_SI,
  output logic                  LdReady_SO,
  input  logic [3:0]            LdBank_DI,
  input  logic [ADDR_WIDTH-1:0] LdAddr_DI,
  input  logic [DATA_WIDTH-1:0] LdData_DI,
  output logic                  LdErr_SO,
  output logic [NUM_BANKS-1:0]  SramCE_SO,
  output logic                  SramWE_SO,
  output logic [ADDR_WIDTH-1:0] SramAddr_DO,
  output logic [DATA_WIDTH-1:0] SramWData_DO
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                r_state, w_state_next;
  logic [LAT_W-1:0]      r_lat_cnt, w_lat_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_hold_addr;
  logic [NUM_MOD-1:0]    r_req;
  logic [DATA_WIDTH-1:0] r_hold_wdata;
  logic                  r_err;

  logic                  w_starve, w_gate, w_can_act, w_issue, w_grant, w_bank_ok;
  logic [NUM_BANKS-1:0]  w_ld_onehot;

  hv_sram_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk      (Clk_CI),
    .rst_n    (Reset_RBI),
    .i_wait   (LdValid_SI && !w_grant),
    .i_clr    (w_grant),
    .o_starve (w_starve)
  );

  assign w_gate      = (EncAddr_DI == r_addr) && (EncReq_SI == r_req);
  assign w_bank_ok   = (LdBank_DI < 4'(NUM_BANKS));
  assign w_ld_onehot = w_bank_ok ? (NUM_BANKS'(1) << LdBank_DI) : '0;

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    w_state_next   = r_state;
    w_lat_cnt_next = r_lat_cnt;
    w_can_act      = 1'b0;
    w_issue        = 1'b0;
    w_grant        = 1'b0;

    case (r_state)
      ST_IDLE: w_can_act = 1'b1;
      ST_RD_WAIT: begin
        w_lat_cnt_next = r_lat_cnt - 1'b1;
        if (w_lat_cnt_next == '0) w_state_next = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (!w_gate) begin
          w_can_act    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // A starving loader wins the next access opportunity over a new read.
    if (Reset_RBI && w_can_act) begin
      if ((EncReq_SI != '0) && !(LdValid_SI && w_starve)) begin
        w_issue        = 1'b1;
        w_lat_cnt_next = LAT_W'(READ_LATENCY - 1);
        w_state_next   = (READ_LATENCY == 1) ? ST_RD_HOLD : ST_RD_WAIT;
      end else if (LdValid_SI) begin
        w_grant = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      r_state      <= ST_IDLE;
      r_lat_cnt    <= '0;
      r_addr       <= '0;
      r_req        <= '0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_cnt_next;
      if (w_issue) begin
        r_addr      <= EncAddr_DI;
        r_req       <= EncReq_SI;
        r_hold_addr <= EncAddr_DI;
      end else if (w_grant) begin
        r_hold_addr  <= LdAddr_DI;
        r_hold_wdata <= LdData_DI;
        if (!w_bank_ok) r_err <= 1'b1;
      end
    end
  end

  // The address/request gate keeps a stale valid from ever reaching the encoder.
  assign EncValid_SO  = (Reset_RBI && (r_state == ST_RD_HOLD) && w_gate) ? req_to_mask(r_req) : '0;
  assign SramCE_SO    = w_issue ? req_to_mask(EncReq_SI) : (w_grant ? w_ld_onehot : '0);
  assign SramWE_SO    = w_grant;
  assign LdReady_SO   = w_grant;
  assign SramAddr_DO  = w_issue ? EncAddr_DI : (w_grant ? LdAddr_DI : r_hold_addr);
  assign SramWData_DO = w_grant ? LdData_DI : r_hold_wdata;
  assign LdErr_SO     = r_err;

endmodule

// File: tb/tb_hv_sram_read_scheduler.sv
// Self-checking bench: two schedulers (read latency 1 and 3) share stimulus and
// are compared every cycle against a transaction-level reference model.
module tb_hv_sram_read_scheduler;

  localparam int DW    = 2000;
  localparam int LIMIT = 16;
  localparam int NDUT  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [2:0]    enc_req;
  logic [7:0]    enc_addr;
  logic          ld_valid;
  logic [3:0]    ld_bank;
  logic [7:0]    ld_addr;
  logic [DW-1:0] ld_data;

  logic [8:0]    valid [NDUT];
  logic [8:0]    ce    [NDUT];
  logic          we    [NDUT];
  logic          rdy   [NDUT];
  logic          err   [NDUT];
  logic [7:0]    saddr [NDUT];
  logic [DW-1:0] wdata [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    hv_sram_read_scheduler #(
      .ADDR_WIDTH  (8),
      .DATA_WIDTH  (DW),
      .READ_LATENCY((g == 0) ? 1 : 3),
      .STARVE_LIMIT(LIMIT)
    ) u_dut (
      .Clk_CI      (clk),
      .Reset_RBI   (rst_n),
      .EncReq_SI   (enc_req),
      .EncAddr_DI  (enc_addr),
      .EncValid_SO (valid[g]),
      .LdValid_SI  (ld_valid),
      .LdReady_SO  (rdy[g]),
      .LdBank_DI   (ld_bank),
      .LdAddr_DI   (ld_addr),
      .LdData_DI   (ld_data),
      .LdErr_SO    (err[g]),
      .SramCE_SO   (ce[g]),
      .SramWE_SO   (we[g]),
      .SramAddr_DO (saddr[g]),
      .SramWData_DO(wdata[g])
    );
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one outstanding read per scheduler, described by the
  // request it serves and the cycle its data becomes valid.
  int            lat [NDUT] = '{1, 3};
  longint        cyc = 0;
  bit            m_busy  [NDUT];
  longint        m_due   [NDUT];
  logic [7:0]    m_addr  [NDUT];
  logic [2:0]    m_req   [NDUT];
  int            m_wait  [NDUT];
  bit            m_err   [NDUT];
  logic [7:0]    m_haddr [NDUT];
  logic [DW-1:0] m_hdata [NDUT];
  bit            e_issue [NDUT];
  bit            e_grant [NDUT];
  bit            e_done  [NDUT];
  logic [8:0]    obs_valid [NDUT];
  logic [8:0]    obs_ce    [NDUT];
  logic [7:0]    obs_addr  [NDUT];

  function automatic logic [8:0] expand(input logic [2:0] r);
    logic [8:0] m;
    for (int b = 0; b < 9; b++) m[b] = r[b / 3];
    return m;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < 63; i++) v = {v[DW-33:0], 32'($urandom)};
    return v;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit            held, match, starve, can_act;
    logic [8:0]    x_valid, x_ce;
    logic [7:0]    x_addr;
    logic [DW-1:0] x_wd;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      held    = m_busy[d] && (cyc >= m_due[d]);
      match   = held && (enc_addr == m_addr[d]) && (enc_req == m_req[d]);
      starve  = (m_wait[d] == LIMIT);
      can_act = !m_busy[d] || (held && !match);
      e_issue[d] = rst_n && can_act && (enc_req != 3'd0) && !(ld_valid && starve);
      e_grant[d] = rst_n && can_act && !e_issue[d] && ld_valid;
      e_done[d]  = held && !match;
      x_valid = (rst_n && match) ? expand(m_req[d]) : 9'd0;
      if (e_issue[d])                     x_ce = expand(enc_req);
      else if (e_grant[d] && ld_bank < 9) x_ce = 9'd1 << ld_bank;
      else                                x_ce = 9'd0;
      x_addr = e_issue[d] ? enc_addr : (e_grant[d] ? ld_addr : m_haddr[d]);
      x_wd   = e_grant[d] ? ld_data : m_hdata[d];
      check($sformatf("d%0d_valid", d), 64'(valid[d]), 64'(x_valid));
      check($sformatf("d%0d_ce", d),    64'(ce[d]),    64'(x_ce));
      check($sformatf("d%0d_we", d),    64'(we[d]),    64'(e_grant[d]));
      check($sformatf("d%0d_ready", d), 64'(rdy[d]),   64'(e_grant[d]));
      check($sformatf("d%0d_err", d),   64'(err[d]),   64'(m_err[d]));
      check($sformatf("d%0d_addr", d),  64'(saddr[d]), 64'(x_addr));
      check($sformatf("d%0d_wdata_eq", d), 64'(wdata[d] === x_wd), 64'd1);
      obs_valid[d] = valid[d];
      obs_ce[d]    = ce[d];
      obs_addr[d]  = saddr[d];
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n) begin
        m_busy[d] = 1'b0; m_wait[d] = 0; m_err[d] = 1'b0;
        m_haddr[d] = '0; m_hdata[d] = '0;
      end else begin
        if (ld_valid && !e_grant[d] && m_wait[d] < LIMIT) m_wait[d]++;
        if (e_grant[d]) begin
          m_wait[d] = 0; m_haddr[d] = ld_addr; m_hdata[d] = ld_data;
          if (ld_bank >= 9) m_err[d] = 1'b1;
        end
        if (e_issue[d]) begin
          m_busy[d] = 1'b1; m_due[d] = cyc + lat[d];
          m_addr[d] = enc_addr; m_req[d] = enc_req; m_haddr[d] = enc_addr;
        end else if (e_done[d]) begin
          m_busy[d] = 1'b0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  int  waits;
  bit  granted;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      m_busy[d] = 1'b0; m_due[d] = 0; m_addr[d] = '0; m_req[d] = '0;
      m_wait[d] = 0; m_err[d] = 1'b0; m_haddr[d] = '0; m_hdata[d] = '0;
    end
    rst_n = 1'b0; enc_req = 3'd0; enc_addr = 8'd0;
    ld_valid = 1'b0; ld_bank = 4'd0; ld_addr = 8'd0; ld_data = '0;
    repeat (2) step();
    check("reset_valid", 64'(obs_valid[0]), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic read, latency 1.
    enc_req = 3'b111; enc_addr = 8'd5;
    step();
    check("basic_ce_T", 64'(obs_ce[0]), 64'h1FF);
    check("basic_addr_T", 64'(obs_addr[0]), 64'd5);
    step();
    check("basic_valid_T1", 64'(obs_valid[0]), 64'h1FF);
    enc_addr = 8'd6;
    step();
    check("basic_valid_T2", 64'(obs_valid[0]), 64'd0);
    check("basic_ce_T2", 64'(obs_ce[0]), 64'h1FF);
    enc_req = 3'd0;
    repeat (6) step();

    // Latency 3, modality 0 only.
    enc_req = 3'b001; enc_addr = 8'd31;
    step();
    check("lat3_ce_T", 64'(obs_ce[1]), 64'h007);
    step();
    check("lat3_ce_T1", 64'(obs_ce[1]), 64'd0);
    step();
    check("lat3_valid_T2", 64'(obs_valid[1]), 64'd0);
    step();
    check("lat3_valid_T3", 64'(obs_valid[1]), 64'h007);
    enc_req = 3'd0;
    step();
    check("lat3_drop", 64'(obs_valid[1]), 64'd0);
    repeat (2) step();

    // Loader write with the encoder idle.
    ld_valid = 1'b1; ld_bank = 4'd4; ld_addr = 8'd10; ld_data = rand_data();
    step();
    check("ld_ce", 64'(obs_ce[0]), 64'h010);
    check("ld_addr", 64'(obs_addr[0]), 64'd10);

    // Write to a nonexistent bank: acknowledged, no CE, sticky error.
    ld_bank = 4'd12; ld_addr = 8'd3; ld_data = rand_data();
    step();
    check("badbank_ce", 64'(obs_ce[0]), 64'd0);
    ld_valid = 1'b0;
    repeat (3) step();
    check("badbank_err_sticky", 64'(err[0]), 64'd1);

    // Starvation: encoder sweeps continuously while the loader waits.
    enc_req = 3'b111; enc_addr = 8'd100;
    ld_valid = 1'b1; ld_bank = 4'd2; ld_addr = 8'd77; ld_data = rand_data();
    granted = 1'b0; waits = 0;
    for (int i = 0; i < 100 && !granted; i++) begin
      step();
      if (e_grant[0]) begin
        granted = 1'b1;
        check("starve_grant_ce", 64'(obs_ce[0]), 64'h004);
      end else begin
        waits++;
        if (obs_valid[0] != 9'd0) enc_addr = enc_addr + 8'd1;
      end
    end
    check("starve_granted", 64'(granted), 64'd1);
    check("starve_wait_len", 64'(waits >= LIMIT && waits <= LIMIT + 1), 64'd1);
    ld_valid = 1'b0;
    step();
    check("starve_read_after", 64'(obs_ce[0]), 64'h1FF);
    enc_req = 3'd0;
    repeat (6) step();

    // Reset one cycle after a latency-3 issue.
    enc_req = 3'b010; enc_addr = 8'd40;
    step();
    rst_n = 1'b0;
    step();
    step();
    check("rst_ce", 64'(obs_ce[1]), 64'd0);
    check("rst_addr", 64'(obs_addr[1]), 64'd0);
    rst_n = 1'b1; enc_req = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_no_valid", 64'(obs_valid[1]), 64'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(63) != 0);
      if ($urandom_range(3) == 0) enc_req = 3'($urandom_range(7));
      if ($urandom_range(2) == 0) enc_addr = 8'($urandom_range(3));
      ld_valid = ($urandom_range(2) == 0);
      ld_bank  = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 9)) : 4'($urandom_range(8));
      ld_addr  = 8'($urandom);
      ld_data  = rand_data();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
